// File: rtl/onewire_temp_sequencer_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | onewire_temp_sequencer_pkg: 1-Wire opcodes, ROM/function bytes, CRC-8 step |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
package onewire_temp_sequencer_pkg;

    localparam logic [1:0] OW_OP_RESET = 2'b00;
    localparam logic [1:0] OW_OP_WRITE = 2'b01;
    localparam logic [1:0] OW_OP_READ  = 2'b10;

    localparam logic [7:0] OW_SKIP_ROM  = 8'hCC;
    localparam logic [7:0] OW_CONVERT_T = 8'h44;
    localparam logic [7:0] OW_READ_SCR  = 8'hBE;
    localparam logic [7:0] OW_CRC_POLY  = 8'h8C;

    localparam int OW_SCRATCH_BYTES = 9;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST1      = 4'd1,
        ST_SKIP1     = 4'd2,
        ST_CONVT     = 4'd3,
        ST_WAIT_CONV = 4'd4,
        ST_RST2      = 4'd5,
        ST_SKIP2     = 4'd6,
        ST_RDSCR     = 4'd7,
        ST_READ      = 4'd8,
        ST_CHECK     = 4'd9,
        ST_DONE      = 4'd10
    } state_e;

    // Dallas/Maxim CRC-8, reflected form: data enters LSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ data[i];
            c  = {1'b0, c[7:1]};
            if (fb) begin
                c = c ^ OW_CRC_POLY;
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onewire_temp_sequencer_crc8.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | onewire_crc8: byte-wide Dallas/Maxim CRC-8 accumulator, one byte per cycle |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module onewire_crc8
    import onewire_temp_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] byte_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_byte(crc_q, byte_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/onewire_temp_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | onewire_temp_sequencer: convert/readout command sequencer for a DS18B20    |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module onewire_temp_sequencer
    import onewire_temp_sequencer_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 27_000_000,
    parameter int CONV_WAIT_US = 750_000,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_presence,
    output logic        busy,
    output logic [15:0] temp_raw,
    output logic        temp_valid,
    output logic        crc_err,
    output logic        no_device
);

    localparam int             WAIT_CYCLES = (CLK_FREQ_HZ / 1_000_000) * CONV_WAIT_US;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam bit             SKIP_WAIT   = (CONV_WAIT_US == 0);
    localparam logic [3:0]     LAST_IDX    = 4'(OW_SCRATCH_BYTES - 1);

    state_e           state_q, state_d;
    logic             wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [15:0]      temp_raw_q, temp_raw_d;
    logic             temp_valid_q, temp_valid_d;
    logic             crc_err_q, crc_err_d;
    logic             no_device_q, no_device_d;
    logic [7:0]       scratch_q [OW_SCRATCH_BYTES];

    logic       is_cmd;
    logic [1:0] sel_op;
    logic [7:0] sel_data;
    logic       rsp_done;
    logic       scratch_we;
    logic       crc_clear;
    logic       crc_en;
    logic [7:0] crc_val;

    onewire_crc8 u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (crc_clear),
        .en      (crc_en),
        .byte_in (rsp_data),
        .crc     (crc_val)
    );

    // Command decode: which states talk to the engine and with what.
    always_comb begin
        is_cmd   = 1'b1;
        sel_op   = OW_OP_RESET;
        sel_data = 8'h00;
        case (state_q)
            ST_RST1, ST_RST2:   sel_op = OW_OP_RESET;
            ST_SKIP1, ST_SKIP2: begin sel_op = OW_OP_WRITE; sel_data = OW_SKIP_ROM;  end
            ST_CONVT:           begin sel_op = OW_OP_WRITE; sel_data = OW_CONVERT_T; end
            ST_RDSCR:           begin sel_op = OW_OP_WRITE; sel_data = OW_READ_SCR;  end
            ST_READ:            sel_op = OW_OP_READ;
            default:            is_cmd = 1'b0;
        endcase
    end

    assign cmd_valid = is_cmd & ~wait_q;
    assign cmd_op    = cmd_valid ? sel_op   : OW_OP_RESET;
    assign cmd_data  = cmd_valid ? sel_data : 8'h00;
    assign rsp_done  = is_cmd & wait_q & rsp_valid;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        temp_raw_d   = temp_raw_q;
        temp_valid_d = 1'b0;
        crc_err_d    = crc_err_q;
        no_device_d  = no_device_q;
        scratch_we   = 1'b0;
        crc_clear    = 1'b0;
        crc_en       = 1'b0;

        if (cmd_valid && cmd_ready) begin
            wait_d = 1'b1;
        end
        if (rsp_done) begin
            wait_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RST1;
                    wait_d      = 1'b0;
                    crc_err_d   = 1'b0;
                    no_device_d = 1'b0;
                end
            end
            ST_RST1, ST_RST2: begin
                if (rsp_done) begin
                    if (!rsp_presence) begin
                        no_device_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = (state_q == ST_RST1) ? ST_SKIP1 : ST_SKIP2;
                    end
                end
            end
            ST_SKIP1: if (rsp_done) state_d = ST_CONVT;
            ST_CONVT: begin
                if (rsp_done) begin
                    if (SKIP_WAIT) begin
                        state_d = ST_RST2;
                    end else begin
                        state_d = ST_WAIT_CONV;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT_CONV: begin
                if (cnt_q == '0) begin
                    state_d = ST_RST2;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SKIP2: if (rsp_done) state_d = ST_RDSCR;
            ST_RDSCR: begin
                crc_clear = 1'b1;
                if (rsp_done) begin
                    state_d = ST_READ;
                    idx_d   = 4'd0;
                end
            end
            ST_READ: begin
                if (rsp_done) begin
                    scratch_we = 1'b1;
                    // The ninth byte is the device's CRC and is compared, not accumulated.
                    crc_en     = (idx_q != LAST_IDX);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (crc_val == scratch_q[LAST_IDX]) begin
                    temp_raw_d   = {scratch_q[1], scratch_q[0]};
                    temp_valid_d = 1'b1;
                end else begin
                    crc_err_d = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wait_q       <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= 4'd0;
            temp_raw_q   <= 16'h0000;
            temp_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            no_device_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            temp_raw_q   <= temp_raw_d;
            temp_valid_q <= temp_valid_d;
            crc_err_q    <= crc_err_d;
            no_device_q  <= no_device_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OW_SCRATCH_BYTES; i++) begin
                scratch_q[i] <= 8'h00;
            end
        end else if (scratch_we) begin
            scratch_q[idx_q] <= rsp_data;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign temp_raw   = temp_raw_q;
    assign temp_valid = temp_valid_q;
    assign crc_err    = crc_err_q;
    assign no_device  = no_device_q;

endmodule
`default_nettype wire

// File: tb/tb_onewire_temp_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_onewire_temp_sequencer: 1-Wire engine model plus scratchpad/CRC model   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_onewire_temp_sequencer;
    import onewire_temp_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_presence;
    logic        busy;
    logic [15:0] temp_raw;
    logic        temp_valid;
    logic        crc_err;
    logic        no_device;

    onewire_temp_sequencer #(
        .CLK_FREQ_HZ  (27_000_000),
        .CONV_WAIT_US (2),
        .CNT_W        (32)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_presence (rsp_presence),
        .busy         (busy),
        .temp_raw     (temp_raw),
        .temp_valid   (temp_valid),
        .crc_err      (crc_err),
        .no_device    (no_device)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Engine configuration and observations
    bit          eng_presence = 1'b1;
    int          eng_rdy      = 0;
    logic [7:0]  eng_bytes [9];
    int          rd_idx       = 0;
    logic [9:0]  cmd_log [$];
    int          tv_count     = 0;
    int          stab_err     = 0;
    int          ncyc         = 0;
    int          conv_rsp_t   = -1;
    int          rst2_t       = -1;
    logic [15:0] model_temp   = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_rd();
        int n = 0;
        foreach (cmd_log[i]) if (cmd_log[i][9:8] == OW_OP_READ) n++;
        return n;
    endfunction

    // Serial reference CRC: process the scratchpad bytes 0..7 bit by bit, LSB first.
    function automatic logic [7:0] model_crc(input logic [7:0] b [9]);
        int r = 0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                int mix = (r ^ (int'(b[k]) >> j)) & 1;
                r = r >> 1;
                if (mix != 0) r = r ^ 'h8C;
            end
        end
        return 8'(r);
    endfunction

    // Engine: accepts one command, answers 1..3 cycles later, optionally stalls cmd_ready.
    initial begin : engine
        int         gap = 0;
        int         wait_n = 0;
        int         stall = 0;
        bit         seen = 1'b0;
        bit         last_vld = 1'b0;
        logic [1:0] last_op = 2'b00, cur_op = 2'b00, hold_op = 2'b00;
        logic [7:0] last_data = 8'h00, cur_data = 8'h00, hold_data = 8'h00;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 8'h00; rsp_presence = 1'b0;
        forever begin
            @(negedge clk);
            ncyc++;
            rsp_valid = 1'b0; rsp_data = 8'h00; rsp_presence = 1'b0;
            if (!rst_n) begin
                cmd_ready = 1'b0; gap = 0; seen = 1'b0; last_vld = 1'b0;
                continue;
            end
            if (temp_valid) tv_count++;
            if (cmd_ready && last_vld) begin
                cmd_log.push_back({last_op, last_data});
                cur_op = last_op; cur_data = last_data;
                gap = $urandom_range(1, 3);
                cmd_ready = 1'b0; seen = 1'b0;
            end
            if (gap > 0) begin
                gap--;
                if (gap == 0) begin
                    rsp_valid = 1'b1;
                    if (cur_op == OW_OP_RESET) rsp_presence = eng_presence;
                    if (cur_op == OW_OP_READ) begin
                        rsp_data = (rd_idx < 9) ? eng_bytes[rd_idx] : 8'h00;
                        rd_idx++;
                    end
                    if (cur_op == OW_OP_WRITE && cur_data == OW_CONVERT_T) conv_rsp_t = ncyc;
                end
            end else if (cmd_valid) begin
                if (!seen) begin
                    seen = 1'b1; hold_op = cmd_op; hold_data = cmd_data; stall = 0;
                    wait_n = (eng_rdy >= 0) ? eng_rdy : int'($urandom_range(0, 3));
                    if (conv_rsp_t >= 0 && rst2_t < 0) rst2_t = ncyc;
                end else if (cmd_op !== hold_op || cmd_data !== hold_data) begin
                    stab_err++;
                end
                if (stall < wait_n) begin
                    stall++; cmd_ready = 1'b0;
                end else begin
                    cmd_ready = 1'b1;
                end
            end else if (seen) begin
                stab_err++;
            end
            last_vld = cmd_valid; last_op = cmd_op; last_data = cmd_data;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_seq(input bit pres, input int rdy, input logic [7:0] b [9], input int mid_start);
        logic [9:0] exp_q [$];
        logic [7:0] c;
        bit         ok;
        eng_presence = pres; eng_rdy = rdy; eng_bytes = b; rd_idx = 0;
        cmd_log.delete(); tv_count = 0; stab_err = 0; conv_rsp_t = -1; rst2_t = -1;
        pulse_start();
        chk("busy_after_start", busy, 1);
        chk("crc_err_cleared", crc_err, 0);
        chk("no_device_cleared", no_device, 0);
        if (mid_start > 0) begin
            for (int i = 0; i < 3000 && count_rd() < mid_start; i++) @(negedge clk);
            chk("reached_read", count_rd() >= mid_start, 1);
            pulse_start();
        end
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        chk("done_in_time", busy, 0);
        repeat (4) @(negedge clk);

        exp_q.push_back({OW_OP_RESET, 8'h00});
        if (pres) begin
            exp_q.push_back({OW_OP_WRITE, OW_SKIP_ROM});
            exp_q.push_back({OW_OP_WRITE, OW_CONVERT_T});
            exp_q.push_back({OW_OP_RESET, 8'h00});
            exp_q.push_back({OW_OP_WRITE, OW_SKIP_ROM});
            exp_q.push_back({OW_OP_WRITE, OW_READ_SCR});
            repeat (9) exp_q.push_back({OW_OP_READ, 8'h00});
        end
        chk("cmd_count", cmd_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++) begin
            chk($sformatf("cmd_%0d", i), cmd_log[i], exp_q[i]);
        end

        c  = model_crc(b);
        ok = pres && (c == b[8]);
        if (ok) model_temp = {b[1], b[0]};
        chk("temp_valid_pulses", tv_count, ok ? 1 : 0);
        chk("crc_err", crc_err, (pres && !ok) ? 1 : 0);
        chk("no_device", no_device, pres ? 0 : 1);
        chk("temp_raw", temp_raw, model_temp);
        chk("cmd_stable", stab_err, 0);
        chk("cmd_valid_idle", cmd_valid, 0);
        if (pres) chk("wait_conv_cycles", rst2_t - conv_rsp_t - 1, 54);
    endtask

    initial begin : main
        logic [7:0] good [9];
        logic [7:0] bad  [9];
        logic [7:0] rb   [9];
        logic [7:0] c;
        good = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        bad  = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1D};
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_temp_raw", temp_raw, 0);
        chk("rst_outputs", {temp_valid, crc_err, no_device, cmd_op, cmd_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("model_crc_ref", model_crc(good), 8'h1C);
        run_seq(1'b1, 0, good, 0);
        chk("happy_temp", temp_raw, 16'h0550);
        run_seq(1'b1, 0, bad, 0);
        run_seq(1'b0, 0, good, 0);
        run_seq(1'b1, -1, good, 0);
        run_seq(1'b1, 5, good, 0);
        run_seq(1'b1, 0, good, 3);

        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 8; k++) rb[k] = 8'($urandom);
            c = model_crc(rb);
            rb[8] = (n % 2 == 0) ? c : (c ^ 8'($urandom_range(1, 255)));
            run_seq(1'b1, -1, rb, 0);
        end

        // Asynchronous reset in the middle of the scratchpad read.
        eng_presence = 1'b1; eng_rdy = 0; eng_bytes = good; rd_idx = 0;
        cmd_log.delete(); conv_rsp_t = -1; rst2_t = -1;
        pulse_start();
        for (int i = 0; i < 3000 && count_rd() < 4; i++) @(negedge clk);
        chk("mid_read_reached", count_rd() >= 4, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_cmd_valid", cmd_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_temp_raw", temp_raw, 0);
        chk("async_outputs", {temp_valid, crc_err, no_device, cmd_op, cmd_data}, 0);
        model_temp = 16'h0000;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_seq(1'b1, 0, good, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
